// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and FSM state type shared by the UART transmitter
// and receiver. The 8E1 parity option is controlled by the UART_TX_PARITY_EN
// macro in uart_tx; nothing in this package depends on it.
package uart_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Frame FSM states. PARITY is only reachable when parity is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity over one data byte: 1 when the byte has an odd number of ones.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO in front of the UART frame FSM.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter; the level is kept in its own register so that the
// fifo_level output is a flop rather than a pointer subtraction.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic [$clog2(FIFO_DEPTH):0] level_next
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign level      = level_q;
  assign level_next = level_d;

  // Next pointers, level and storage; a push and pop together leave the level alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + PW'(1);
      2'b01:   level_d = level_q - PW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer/level registers with synchronous reset; storage is not reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter for the TXD pin (8E1 when the macro
// UART_TX_PARITY_EN is defined). Bytes enter through a valid/ready port into
// uart_tx_fifo; a frame FSM serialises them LSB-first at BAUD_DIV clocks per bit.
//
// Handshake: a byte transfers on every rising edge where tx_valid && tx_ready.
// tx_data is sampled only on that edge. tx_ready depends only on FIFO full (and
// resetn); tx_valid may stay asserted while tx_ready is low, in which case the
// producer is free to change tx_data until the accepting edge.
//
// TXD is registered from the current FSM state, so the line trails the state
// register by one clock: a byte pushed at edge N is popped at N+1 and TXD falls
// after N+2.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        TXD,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int            CW       = $clog2(BAUD_DIV);
  localparam int            LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic           fifo_push;
  logic           fifo_pop;
  logic [7:0]     fifo_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [LW-1:0]  fifo_level_next;
  logic           cnt_last;

  assign tx_ready  = !fifo_full && resetn;
  assign fifo_push = tx_valid && tx_ready;
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign TXD       = txd_q;
  assign busy      = busy_q;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (fifo_push),
    .push_data  (tx_data),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level),
    .level_next (fifo_level_next)
  );

  // Frame FSM next state, baud counter, shifter and the line level to register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = UART_IDLE_LEVEL;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        txd_d = UART_IDLE_LEVEL;
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
          par_d    = uart_even_parity(fifo_data);
`endif
          state_d  = START;
        end
      end
      START: begin
        txd_d = UART_START_LEVEL;
        if (cnt_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (cnt_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = par_q;
        if (cnt_last) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        txd_d = UART_IDLE_LEVEL;
        if (cnt_last) begin
          // Chain straight into the next frame so there is no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
            par_d    = uart_even_parity(fifo_data);
`endif
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // busy looks ahead one edge so it drops exactly as the FSM enters IDLE empty.
  always_comb begin
    busy_d = (state_d != IDLE) || (fifo_level_next != '0);
  end

  // State and datapath registers; reset parks the line high and drops the frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= UART_IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (BAUD_DIV=4, FIFO_DEPTH=4).
// Honours UART_TX_PARITY_EN to expect 8E1 frames instead of 8N1.
module tb_uart_tx;

  localparam int B     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * B;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          busy;
  logic [LW-1:0] fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  logic       rx_par_q[$];

  uart_tx #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TXD        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference line model: level expected k clocks after the start bit begins.
  function automatic logic line_model(input logic [7:0] d, input int k);
    int idx;
    if (k < 0 || k >= FRAME) return 1'b1;
    idx = k / B;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && NBITS == 11) return (($countones(d) % 2) == 1);
    return 1'b1;
  endfunction

  // ---------------- line monitor: decodes frames sampled on negedges ----------------
  always begin : monitor
    logic [7:0] d;
    logic       p;
    logic       v;
    logic       bad;
    logic       abort;
    int         st;
    @(negedge clk);
    if (resetn === 1'b1 && txd === 1'b0) begin
      st = cyc; bad = 1'b0; abort = 1'b0; d = '0; p = 1'b0; v = 1'b0;
      for (int b = 0; b < NBITS; b++) begin
        for (int i = 0; i < B; i++) begin
          if (!(b == 0 && i == 0)) @(negedge clk);
          if (resetn !== 1'b1) abort = 1'b1;
          if (i == 0) v = txd;
          else if (txd !== v) bad = 1'b1;
        end
        if (b == NBITS - 1) begin
          if (v !== 1'b1) bad = 1'b1;
        end else if (b >= 1 && b <= 8) begin
          d[b-1] = v;
        end else if (b == 9) begin
          p = v;
        end
      end
      if (!abort) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL frame_shape start_cyc=%0d data=%02h: bit not held %0d clocks or stop not high", st, d, B);
        end
        rx_q.push_back(d);
        rx_cyc_q.push_back(st);
        rx_par_q.push_back(p);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Offers one byte; garbage sits on tx_data while tx_ready is low.
  task automatic push_byte(input logic [7:0] data, output int acc_cyc);
    int guard;
    guard   = 0;
    acc_cyc = -1;
    @(negedge clk);
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && guard < 4 * FRAME) begin
      tx_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      guard++;
    end
    if (tx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL push_timeout tx_ready=%b required 1", tx_ready);
      tx_valid = 1'b0;
    end else begin
      tx_data = data;
      step();
      acc_cyc  = cyc;
      tx_valid = 1'b0;
      exp_q.push_back(data);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 16 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic clear_queues();
    exp_q.delete(); rx_q.delete(); rx_cyc_q.delete(); rx_par_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_level !== LW'(0)) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got=%b exp=0", tx_ready); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high got=%b exp=1", tx_ready); end
    step();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL post_reset_txd got=%b exp=1", txd); end
  endtask

  task automatic test_single_byte();
    int n;
    int bad_txd;
    int bad_busy;
    logic eb;
    clear_queues();
    bad_txd = 0; bad_busy = 0;
    push_byte(8'h55, n);
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL single_level_push got=%0d exp=1", fifo_level); end
    // busy rises on the push edge N and falls on the edge N+FRAME+1 where the FSM returns to IDLE.
    for (int i = 0; i < FRAME + 6; i++) begin
      checks++;
      if (txd !== line_model(8'h55, cyc - (n + 2))) begin
        errors++; bad_txd++;
        $display("FAIL single_txd cyc=%0d got=%b exp=%b", cyc - n, txd, line_model(8'h55, cyc - (n + 2)));
      end
      eb = ((cyc - n) <= FRAME);
      checks++;
      if (busy !== eb) begin
        errors++; bad_busy++;
        $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc - n, busy, eb);
      end
      if (cyc == n + 1) begin
        checks++; if (fifo_level !== LW'(0)) begin errors++; $display("FAIL single_level_pop got=%0d exp=0", fifo_level); end
      end
      step();
    end
    wait_idle();
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL single_count got=%0d exp=1", rx_q.size());
    end else begin
      checks++; if (rx_q[0] !== 8'h55) begin errors++; $display("FAIL single_data got=%02h exp=55", rx_q[0]); end
      checks++; if (rx_cyc_q[0] != n + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", rx_cyc_q[0] - n, 2); end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    int n;
    logic [7:0] bytes [3];
    clear_queues();
    bytes[0] = 8'hA0; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
    push_byte(8'h11, n0);
    for (int i = 0; i < 3; i++) begin
      push_byte(bytes[i], n);
      checks++; if (n != n0 + 1 + i) begin errors++; $display("FAIL b2b_accept_cyc got=%0d exp=%0d", n - n0, 1 + i); end
      checks++; if (fifo_level !== LW'(i + 1)) begin errors++; $display("FAIL b2b_level_fill got=%0d exp=%0d", fifo_level, i + 1); end
    end
    for (int k = 1; k <= 3; k++) begin
      wait_until(n0 + FRAME * k);
      checks++; if (fifo_level !== LW'(4 - k)) begin errors++; $display("FAIL b2b_level_before_pop%0d got=%0d exp=%0d", k, fifo_level, 4 - k); end
      step();
      checks++; if (fifo_level !== LW'(3 - k)) begin errors++; $display("FAIL b2b_level_after_pop%0d got=%0d exp=%0d", k, fifo_level, 3 - k); end
    end
    wait_idle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%02h exp=%02h", i, rx_q[i], exp_q[i]); end
    end
    for (int i = 1; i < rx_cyc_q.size(); i++) begin
      checks++; if (rx_cyc_q[i] - rx_cyc_q[i-1] != FRAME) begin errors++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, rx_cyc_q[i] - rx_cyc_q[i-1], FRAME); end
    end
  endtask

  task automatic test_fifo_full();
    int acc [6];
    int exp_acc;
    clear_queues();
    for (int i = 0; i < 6; i++) begin
      push_byte(8'($urandom_range(0, 255)), acc[i]);
      if (i == 4) begin
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", tx_ready); end
        checks++; if (fifo_level !== LW'(DEPTH)) begin errors++; $display("FAIL full_level got=%0d exp=%0d", fifo_level, DEPTH); end
      end
    end
    // First byte pops at once; the sixth waits for the pop at the end of frame one.
    for (int i = 1; i < 6; i++) begin
      exp_acc = (i <= 4) ? acc[0] + i : acc[0] + FRAME + 2;
      checks++; if (acc[i] != exp_acc) begin errors++; $display("FAIL full_accept_cyc[%0d] got=%0d exp=%0d", i, acc[i] - acc[0], exp_acc - acc[0]); end
    end
    wait_idle();
    checks++;
    if (rx_q.size() != 6) begin
      errors++; $display("FAIL full_count got=%0d exp=6", rx_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_data[%0d] got=%02h exp=%02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int m;
    int bad;
    clear_queues();
    bad = 0;
    push_byte(8'h3C, n);
    push_byte(8'($urandom_range(0, 255)), m);
    push_byte(8'($urandom_range(0, 255)), m);
    wait_until(n + 2 + 4 * B + 1);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_bit3 got=%b exp=1", txd); end
    @(negedge clk);
    resetn = 1'b0;
    step();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd got=%b exp=1", txd); end
    checks++; if (fifo_level !== LW'(0)) begin errors++; $display("FAIL rst_mid_level got=%0d exp=0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0", tx_ready); end
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet got=%0d active cycles exp=0", bad); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rst_mid_frames got=%0d exp=0", rx_q.size()); end
    clear_queues();
  endtask

  task automatic test_random();
    int n;
    int gap;
    clear_queues();
    for (int i = 0; i < 10; i++) begin
      gap = $urandom_range(0, FRAME + B);
      repeat (gap) begin
        @(negedge clk);
        tx_data = 8'($urandom_range(0, 255));
      end
      push_byte(8'($urandom_range(0, 255)), n);
    end
    wait_idle();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got=%02h exp=%02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int n;
    logic [7:0] bytes [2];
    logic       exp_p;
    clear_queues();
    bytes[0] = 8'h07; bytes[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      push_byte(bytes[i], n);
      wait_idle();
    end
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL par_count got=%0d exp=2", rx_q.size());
    end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      exp_p = (($countones(bytes[i]) % 2) == 1);
      checks++; if (rx_q[i] !== bytes[i]) begin errors++; $display("FAIL par_data[%0d] got=%02h exp=%02h", i, rx_q[i], bytes[i]); end
      checks++; if (rx_par_q[i] !== exp_p) begin errors++; $display("FAIL par_bit[%0d] got=%b exp=%b", i, rx_par_q[i], exp_p); end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    resetn   = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    checks++;
    $display("FAIL watchdog cyc=%0d required test sequence to end", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
